// File: rtl/adder_tree_pkg.sv
// Sizing helpers for the pipelined adder tree: per-level element count and width,
// plus the operand-count legality test used at elaboration.
package adder_tree_pkg;

   // Number of elements held by tree level s (level 0 is the raw operand vector).
   function automatic int stage_count(input int n, input int s);
      return (n + (1 << s) - 1) >> s;
   endfunction

   // Each level adds exactly one bit of headroom so no sum can wrap.
   function automatic int stage_width(input int w, input int s);
      return w + s;
   endfunction

   function automatic bit num_inputs_legal(input int n);
      return n >= 2;
   endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered level of the adder tree: pairwise sign-extended adds, and an odd
// trailing element is sign-extended and carried through without an add.
module adder_tree_stage
   import adder_tree_pkg::*;
#(
   parameter  int IN_W    = 16,
   parameter  int IN_CNT  = 2,
   localparam int OUT_W   = IN_W + 1,
   localparam int OUT_CNT = (IN_CNT + 1) / 2
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic [IN_CNT-1:0][IN_W-1:0]      din,
   output logic [OUT_CNT-1:0][OUT_W-1:0]    dout
);

   localparam int NPAIR = IN_CNT / 2;

   logic [OUT_CNT-1:0][OUT_W-1:0] nxt;

   always_comb begin
      nxt = '0;
      for (int k = 0; k < NPAIR; k++) begin
         nxt[k] = {din[2*k][IN_W-1], din[2*k]} + {din[2*k+1][IN_W-1], din[2*k+1]};
      end
      if ((IN_CNT % 2) == 1) begin
         nxt[OUT_CNT-1] = {din[IN_CNT-1][IN_W-1], din[IN_CNT-1]};
      end
   end

   // resetn is active-high here: a 1 clears the level on the next edge.
   always_ff @(posedge clk) begin
      if (resetn) begin
         dout <= '0;
      end else begin
         dout <= nxt;
      end
   end

endmodule

// File: rtl/adder_tree.sv
// Fully pipelined signed adder tree, one vector per clock, exact full-precision sum.
// Define ADDER_TREE_IN_REG_EN to add an input register bank (one extra cycle of latency).
module adder_tree
   import adder_tree_pkg::*;
#(
   parameter  int INPUT_WIDTH  = 16,
   parameter  int NUM_INPUTS   = 53,
   localparam int NUM_STAGES   = $clog2(NUM_INPUTS),
   localparam int OUTPUT_WIDTH = INPUT_WIDTH + NUM_STAGES
) (
   input  logic                                    clk,
   input  logic                                    resetn,
   input  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0]  inputd,
   output logic signed [OUTPUT_WIDTH-1:0]          sum
);

   if (!num_inputs_legal(NUM_INPUTS)) begin : g_bad_count
      $error("adder_tree: NUM_INPUTS must be >= 2");
   end

   logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] stage0;

`ifdef ADDER_TREE_IN_REG_EN
   always_ff @(posedge clk) begin
      if (resetn) begin
         stage0 <= '0;
      end else begin
         stage0 <= inputd;
      end
   end
`else
   assign stage0 = inputd;
`endif

   for (genvar s = 1; s <= NUM_STAGES; s++) begin : g_stage
      localparam int IN_CNT = stage_count(NUM_INPUTS, s - 1);
      localparam int IN_W   = stage_width(INPUT_WIDTH, s - 1);

      logic [IN_CNT-1:0][IN_W-1:0] din;
      logic [stage_count(NUM_INPUTS, s)-1:0][stage_width(INPUT_WIDTH, s)-1:0] data;

      if (s == 1) begin : g_first
         assign din = stage0;
      end else begin : g_next
         assign din = g_stage[s-1].data;
      end

      adder_tree_stage #(
         .IN_W   (IN_W),
         .IN_CNT (IN_CNT)
      ) u_stage (
         .clk    (clk),
         .resetn (resetn),
         .din    (din),
         .dout   (data)
      );
   end

   // The last level always holds exactly one element since 2**NUM_STAGES >= NUM_INPUTS.
   assign sum = g_stage[NUM_STAGES].data[0];

endmodule

// File: tb/tb_adder_tree.sv
// Scoreboard bench for adder_tree: stimulus pushes hand-computed sums, a monitor
// tracks issue slots through the pipeline latency and pops/compares at the output.
module tb_adder_tree;

   localparam int W  = 16;
   localparam int N  = 53;
   localparam int NS = $clog2(N);
   localparam int OW = W + NS;
`ifdef ADDER_TREE_IN_REG_EN
   localparam int LAT = NS + 1;
`else
   localparam int LAT = NS;
`endif

   typedef logic [N-1:0][W-1:0] vec_t;

   logic                  clk    = 1'b0;
   logic                  resetn = 1'b1;
   vec_t                  inputd;
   logic signed [OW-1:0]  sum;

   logic                  issue = 1'b0;
   bit                    armed = 1'b0;
   logic [LAT-1:0]        vld   = '0;
   logic signed [OW-1:0]  exp_q[$];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   adder_tree #(
      .INPUT_WIDTH (W),
      .NUM_INPUTS  (N)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .inputd (inputd),
      .sum    (sum)
   );

   task automatic check(input string name, input logic signed [OW-1:0] act,
                        input logic signed [OW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: sum=%0d expected=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: inputs change only on negedge, so values seen at posedge are what the DUT sampled.
   always @(posedge clk) begin
      logic r;
      logic i;
      logic signed [OW-1:0] e;
      r = resetn;
      i = issue;
      #1;
      if (r) begin
         armed = 1'b1;
         vld   = '0;
         exp_q.delete();
         check("reset", sum, '0);
      end else if (armed) begin
         vld = {vld[LAT-2:0], i};
         if (vld[LAT-1]) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL underflow: sum=%0d with no expected value queued", sum);
            end else begin
               e = exp_q.pop_front();
               check("data", sum, e);
            end
         end else begin
            check("idle", sum, '0);
         end
      end
   end

   function automatic vec_t fill(input int v);
      vec_t r;
      for (int k = 0; k < N; k++) r[k] = v[W-1:0];
      return r;
   endfunction

   function automatic vec_t one_hot(input int idx, input int v);
      vec_t r;
      r = '0;
      r[idx] = v[W-1:0];
      return r;
   endfunction

   task automatic drive(input vec_t v, input logic signed [OW-1:0] e);
      @(negedge clk);
      resetn = 1'b0;
      inputd = v;
      issue  = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         resetn = 1'b0;
         inputd = '0;
         issue  = 1'b0;
      end
   endtask

   task automatic do_reset(input int n);
      repeat (n) begin
         @(negedge clk);
         resetn = 1'b1;
         inputd = 'x;
         issue  = 1'b0;
      end
   endtask

   initial begin
      inputd = 'x;
      do_reset(3);
      idle(2);

      drive(fill(1), 53);
      idle(LAT + 1);

      drive(fill(-1),     -53);
      drive(fill(32767),  1736651);
      drive(fill(-32768), -1736704);
      drive(one_hot(52, 5), 5);
      drive(one_hot(0, -7), -7);
      idle(LAT + 1);

      drive(fill(1), 53);
      drive(fill(2), 106);
      drive(fill(3), 159);
      idle(LAT + 1);

      // Reset with vectors in flight: none of these sums may ever reach the output.
      drive(fill(100), 5300);
      drive(fill(200), 10600);
      drive(fill(-300), -15900);
      do_reset(1);
      idle(LAT + 2);

      drive(fill(1), 53);
      idle(LAT + 2);

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected sums never appeared", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
